// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Arbiter/sequencer for a single byte-wide RAM port shared by
//            instruction fetch (IF) and the MEM stage. Splits 1/2/4-byte
//            reads and writes into per-byte RAM cycles and assembles
//            little-endian read words.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [31:0]       if_inst_o,
    output logic              if_done_o,
    // MEM stage port
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    // RAM port
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_IF_RD  = 3'd1;
    localparam logic [2:0] c_MEM_RD = 3'd2;
    localparam logic [2:0] c_MEM_WR = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        r_cnt;     // next byte index k (1..N) while busy
    logic [2:0]        r_n;       // byte count of the granted transaction
    logic              r_is_mem;  // owner of the transaction in flight / DONE
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;     // partially assembled read word

    logic [2:0]        w_state_nxt;
    logic [2:0]        w_cnt_nxt;
    logic [2:0]        w_n_nxt;
    logic              w_is_mem_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [31:0]       w_wdata_nxt;
    logic [31:0]       w_buf_nxt;
    logic [ADDR_W-1:0] w_ram_addr_nxt;
    logic              w_ram_we_nxt;
    logic [7:0]        w_ram_dout_nxt;
    logic [31:0]       w_if_inst_nxt;
    logic [31:0]       w_mem_rdata_nxt;

    logic [ADDR_W-1:0] w_addr_k;
    logic [7:0]        w_wbyte_k;
    logic [31:0]       w_rd_word;
    logic              w_last;

    // Per-byte helpers: address addr+k (wraps), store byte k, and the read
    // word with the byte arriving this cycle (index k-1) merged in.
    always_comb begin
        w_addr_k  = r_addr + ADDR_W'(r_cnt);
        w_last    = (r_cnt == r_n);
        w_wbyte_k = r_wdata[7:0];
        w_rd_word = r_buf;
        case (r_cnt[1:0])
            2'd1: begin
                w_wbyte_k       = r_wdata[15:8];
                w_rd_word[7:0]  = ram_din_i;
            end
            2'd2: begin
                w_wbyte_k       = r_wdata[23:16];
                w_rd_word[15:8] = ram_din_i;
            end
            2'd3: begin
                w_wbyte_k        = r_wdata[31:24];
                w_rd_word[23:16] = ram_din_i;
            end
            default: begin
                w_rd_word[31:24] = ram_din_i;
            end
        endcase
    end

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_n_nxt         = r_n;
        w_is_mem_nxt    = r_is_mem;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_buf_nxt       = r_buf;
        w_ram_addr_nxt  = ram_addr_o;
        w_ram_we_nxt    = ram_we_o;
        w_ram_dout_nxt  = ram_dout_o;
        w_if_inst_nxt   = if_inst_o;
        w_mem_rdata_nxt = mem_rdata_o;

        case (r_state)
            c_IDLE: begin
                if (mem_req_i) begin
                    // MEM wins over IF; IF keeps its request held.
                    w_is_mem_nxt = 1'b1;
                    w_addr_nxt   = mem_addr_i;
                    w_wdata_nxt  = mem_wdata_i;
                    w_buf_nxt    = '0;
                    w_cnt_nxt    = 3'd1;
                    case (mem_sel_i)
                        2'b01:   w_n_nxt = 3'd1;
                        2'b10:   w_n_nxt = 3'd2;
                        default: w_n_nxt = 3'd4;
                    endcase
                    if (mem_sel_i == 2'b00) begin
                        // NOP: complete without touching the RAM.
                        w_cnt_nxt       = 3'd0;
                        w_mem_rdata_nxt = '0;
                        w_state_nxt     = c_DONE;
                    end else if (mem_we_i) begin
                        w_ram_we_nxt   = 1'b1;
                        w_ram_addr_nxt = mem_addr_i;
                        w_ram_dout_nxt = mem_wdata_i[7:0];
                        w_state_nxt    = c_MEM_WR;
                    end else begin
                        w_ram_addr_nxt = mem_addr_i;
                        w_state_nxt    = c_MEM_RD;
                    end
                end else if (if_req_i && !if_flush_i) begin
                    w_is_mem_nxt   = 1'b0;
                    w_addr_nxt     = if_addr_i;
                    w_buf_nxt      = '0;
                    w_n_nxt        = 3'd4;
                    w_cnt_nxt      = 3'd1;
                    w_ram_addr_nxt = if_addr_i;
                    w_state_nxt    = c_IF_RD;
                end
            end

            c_IF_RD, c_MEM_RD: begin
                if ((r_state == c_IF_RD) && if_flush_i) begin
                    // Branch redirect abandons the fetch without a pulse.
                    w_cnt_nxt      = 3'd0;
                    w_ram_addr_nxt = '0;
                    w_state_nxt    = c_IDLE;
                end else begin
                    w_buf_nxt = w_rd_word;
                    if (w_last) begin
                        w_cnt_nxt      = 3'd0;
                        w_ram_addr_nxt = '0;
                        w_state_nxt    = c_DONE;
                        if (r_is_mem) begin
                            w_mem_rdata_nxt = w_rd_word;
                        end else begin
                            w_if_inst_nxt = w_rd_word;
                        end
                    end else begin
                        w_ram_addr_nxt = w_addr_k;
                        w_cnt_nxt      = r_cnt + 3'd1;
                    end
                end
            end

            c_MEM_WR: begin
                if (w_last) begin
                    w_cnt_nxt      = 3'd0;
                    w_ram_we_nxt   = 1'b0;
                    w_ram_addr_nxt = '0;
                    w_ram_dout_nxt = '0;
                    w_state_nxt    = c_DONE;
                end else begin
                    w_ram_addr_nxt = w_addr_k;
                    w_ram_dout_nxt = w_wbyte_k;
                    w_cnt_nxt      = r_cnt + 3'd1;
                end
            end

            c_DONE: begin
                w_state_nxt = c_IDLE;
            end

            default: begin
                w_cnt_nxt      = 3'd0;
                w_ram_we_nxt   = 1'b0;
                w_ram_addr_nxt = '0;
                w_ram_dout_nxt = '0;
                w_state_nxt    = c_IDLE;
            end
        endcase
    end

    // State, latched request fields and registered RAM/data outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 3'd0;
            r_n         <= 3'd0;
            r_is_mem    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            ram_addr_o  <= '0;
            ram_we_o    <= 1'b0;
            ram_dout_o  <= '0;
            if_inst_o   <= '0;
            mem_rdata_o <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_n         <= w_n_nxt;
            r_is_mem    <= w_is_mem_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_buf       <= w_buf_nxt;
            ram_addr_o  <= w_ram_addr_nxt;
            ram_we_o    <= w_ram_we_nxt;
            ram_dout_o  <= w_ram_dout_nxt;
            if_inst_o   <= w_if_inst_nxt;
            mem_rdata_o <= w_mem_rdata_nxt;
        end
    end

    // Completion pulses are the single DONE cycle, routed to its owner.
    always_comb begin
        if_done_o  = (r_state == c_DONE) && !r_is_mem;
        mem_done_o = (r_state == c_DONE) && r_is_mem;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed self-checking bench for mem_ctrl with a combinational
//            byte RAM model answering for the address of the current cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_inst;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    int checks = 0;
    int errors = 0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_flush_i  (if_flush),
        .if_inst_o   (if_inst),
        .if_done_o   (if_done),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_sel_i   (mem_sel),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .mem_done_o  (mem_done),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_dout_o  (ram_dout),
        .ram_din_i   (ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents: the byte for the address currently driven is sampled by
    // the DUT at the next edge.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h0000_0100: ram_byte = 8'h13;
            32'h0000_0101: ram_byte = 8'h00;
            32'h0000_0102: ram_byte = 8'h50;
            32'h0000_0103: ram_byte = 8'h00;
            32'h0000_0020: ram_byte = 8'h80;
            32'h0000_0000: ram_byte = 8'h11;
            32'h0000_0001: ram_byte = 8'h22;
            32'h0000_0002: ram_byte = 8'h33;
            32'h0000_0003: ram_byte = 8'h44;
            32'h0000_0200: ram_byte = 8'hA1;
            32'h0000_0201: ram_byte = 8'hB2;
            32'h0000_0202: ram_byte = 8'hC3;
            32'h0000_0203: ram_byte = 8'hD4;
            default:       ram_byte = 8'h00;
        endcase
    endfunction

    assign ram_din = ram_byte(ram_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        tick();
        tick();
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_we", {31'b0, ram_we}, 32'h0);
        check("rst_done", {30'b0, if_done, mem_done}, 32'h0);
        check("rst_data", if_inst | mem_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // 1. IF word at 0x100
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        check("t1_addr0", ram_addr, 32'h100);
        check("t1_we", {31'b0, ram_we}, 32'h0);
        tick();
        check("t1_addr1", ram_addr, 32'h101);
        tick();
        check("t1_addr2", ram_addr, 32'h102);
        tick();
        check("t1_addr3", ram_addr, 32'h103);
        check("t1_nodone_early", {31'b0, if_done}, 32'h0);
        tick();
        check("t1_done", {31'b0, if_done}, 32'h1);
        check("t1_inst", if_inst, 32'h0050_0013);
        check("t1_addr_idle", ram_addr, 32'h0);
        if_req = 1'b0;
        tick();
        check("t1_done_1cyc", {31'b0, if_done}, 32'h0);
        check("t1_inst_hold", if_inst, 32'h0050_0013);

        // 2. simultaneous IF@0x0 and lb@0x20: MEM first
        if_req   = 1'b1;
        if_addr  = 32'h0;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_sel  = 2'b01;
        mem_addr = 32'h20;
        tick();
        check("t2_mem_first", ram_addr, 32'h20);
        tick();
        check("t2_mem_done", {30'b0, if_done, mem_done}, 32'h1);
        check("t2_rdata", mem_rdata, 32'h0000_0080);
        mem_req = 1'b0;
        tick();
        check("t2_idle_after_done", ram_addr, 32'h0);
        check("t2_mem_done_1cyc", {31'b0, mem_done}, 32'h0);
        tick();
        tick();
        check("t2_if_addr1", ram_addr, 32'h1);
        tick();
        tick();
        tick();
        check("t2_if_done", {30'b0, if_done, mem_done}, 32'h2);
        check("t2_if_inst", if_inst, 32'h4433_2211);
        check("t2_rdata_hold", mem_rdata, 32'h0000_0080);
        if_req = 1'b0;
        tick();

        // 3. sw 0xDEADBEEF @0x1000
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_sel   = 2'b11;
        mem_addr  = 32'h1000;
        mem_wdata = 32'hDEAD_BEEF;
        tick();
        check("t3_b0", {ram_we, ram_addr[22:0], ram_dout}, {1'b1, 23'h1000, 8'hEF});
        mem_wdata = 32'h0;   // latched at grant, must be ignored now
        tick();
        check("t3_b1", {ram_we, ram_addr[22:0], ram_dout}, {1'b1, 23'h1001, 8'hBE});
        tick();
        check("t3_b2", {ram_we, ram_addr[22:0], ram_dout}, {1'b1, 23'h1002, 8'hAD});
        tick();
        check("t3_b3", {ram_we, ram_addr[22:0], ram_dout}, {1'b1, 23'h1003, 8'hDE});
        check("t3_nodone_early", {31'b0, mem_done}, 32'h0);
        tick();
        check("t3_end", {ram_we, ram_addr[22:0], ram_dout}, 32'h0);
        check("t3_done", {31'b0, mem_done}, 32'h1);
        mem_req = 1'b0;
        tick();

        // 4. sh 0x1234 @0xFFFFFFFF (wrap)
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_sel   = 2'b10;
        mem_addr  = 32'hFFFF_FFFF;
        mem_wdata = 32'h0000_1234;
        tick();
        check("t4_addr0", ram_addr, 32'hFFFF_FFFF);
        check("t4_b0", {23'b0, ram_we, ram_dout}, {23'b0, 1'b1, 8'h34});
        tick();
        check("t4_addr1_wrap", ram_addr, 32'h0);
        check("t4_b1", {23'b0, ram_we, ram_dout}, {23'b0, 1'b1, 8'h12});
        tick();
        check("t4_end_we", {31'b0, ram_we}, 32'h0);
        check("t4_done", {31'b0, mem_done}, 32'h1);
        mem_req = 1'b0;
        tick();

        // 5. IF with flush after byte 1, then new IF@0x200
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        check("t5_addr0", ram_addr, 32'h100);
        tick();
        check("t5_addr1", ram_addr, 32'h101);
        if_flush = 1'b1;
        tick();
        check("t5_flush_idle", ram_addr, 32'h0);
        check("t5_no_done", {31'b0, if_done}, 32'h0);
        if_flush = 1'b0;
        if_addr  = 32'h200;
        tick();
        check("t5_new_grant", ram_addr, 32'h200);
        tick();
        tick();
        tick();
        check("t5_no_done_mid", {31'b0, if_done}, 32'h0);
        tick();
        check("t5_done", {31'b0, if_done}, 32'h1);
        check("t5_inst", if_inst, 32'hD4C3_B2A1);
        if_req = 1'b0;
        tick();

        // 6. reset mid word store, then MEM NOP
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_sel   = 2'b11;
        mem_addr  = 32'h1000;
        mem_wdata = 32'h0102_0304;
        tick();
        tick();
        check("t6_pre_rst", {ram_we, ram_addr[22:0], ram_dout}, {1'b1, 23'h1001, 8'h03});
        #2;
        rst     = 1'b1;
        mem_req = 1'b0;
        #1;
        check("t6_rst_async", {ram_we, ram_addr[22:0], ram_dout}, 32'h0);
        check("t6_rst_data", if_inst | mem_rdata, 32'h0);
        #2;
        rst = 1'b0;
        tick();
        check("t6_idle", {ram_we, ram_addr[22:0], ram_dout}, 32'h0);
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_sel   = 2'b00;
        mem_addr  = 32'h20;
        tick();
        check("t6_nop_done", {30'b0, if_done, mem_done}, 32'h1);
        check("t6_nop_noaccess", {ram_we, ram_addr[22:0], ram_dout}, 32'h0);
        check("t6_nop_rdata", mem_rdata, 32'h0);
        mem_req = 1'b0;
        tick();
        check("t6_nop_1cyc", {31'b0, mem_done}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
